// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and types for the register file scoreboard.
// REG_ADDR/REG_SIZE and the pending-counter width live here for all files.
package regfile_scoreboard_pkg;
  localparam int REG_ADDR = 5;
  localparam int REG_SIZE = 32;
  localparam int PEND_W   = 2;
  localparam int NUM_REGS = 1 << REG_ADDR;

  typedef logic [REG_ADDR-1:0] addr_t;
  typedef logic [REG_SIZE-1:0] data_t;
  typedef logic [PEND_W-1:0]   pend_t;

  localparam pend_t PEND_MAX = '1;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue/writeback bundle between the pipeline and the register scoreboard.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  addr_t               src_reg1;
  addr_t               src_reg2;
  data_t               rin_reg1;
  data_t               rin_reg2;
  logic                issue_valid;
  addr_t               issue_dst;
  logic                issue_ready;
  logic                wb_we;
  addr_t               wb_addr;
  data_t               wb_data;
  logic                stall;
  logic [NUM_REGS-1:0] busy_mask;

  modport master (
    output src_reg1, src_reg2, issue_valid, issue_dst, wb_we, wb_addr, wb_data,
    input  rin_reg1, rin_reg2, issue_ready, stall, busy_mask
  );

  modport slave (
    input  src_reg1, src_reg2, issue_valid, issue_dst, wb_we, wb_addr, wb_data,
    output rin_reg1, rin_reg2, issue_ready, stall, busy_mask
  );
endinterface

// File: rtl/regfile_array.sv
// 2-read / 1-write register storage; entry 0 is hardwired to zero.
module regfile_array
  import regfile_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  addr_t raddr1,
  input  addr_t raddr2,
  output data_t rdata1,
  output data_t rdata2,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata
);

  data_t mem_q [NUM_REGS];
  data_t mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters and RAW stall detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and drop the matching stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input logic           clk,
  input logic           reset,
  regfile_scoreboard_if.slave rf
);

  pend_t               pend_q [NUM_REGS];
  pend_t               pend_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wb_fire;
  logic                wb_hits_issue;
  logic                issue_ready;
  logic                issue_acc;
  data_t               stored1;
  data_t               stored2;
  logic                haz1;
  logic                haz2;

  regfile_array u_array (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rf.src_reg1),
    .raddr2 (rf.src_reg2),
    .rdata1 (stored1),
    .rdata2 (stored2),
    .we     (rf.wb_we),
    .waddr  (rf.wb_addr),
    .wdata  (rf.wb_data)
  );

  assign wb_fire       = rf.wb_we && (rf.wb_addr != '0);
  assign wb_hits_issue = wb_fire && (rf.wb_addr == rf.issue_dst);
  // A full counter can still take an issue if a writeback retires one in the same edge.
  assign issue_ready   = !((pend_q[rf.issue_dst] == PEND_MAX) && !wb_hits_issue);
  assign issue_acc     = rf.issue_valid && issue_ready && (rf.issue_dst != '0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc;
      logic dec;
      inc       = issue_acc && (rf.issue_dst == addr_t'(r));
      dec       = wb_fire && (rf.wb_addr == addr_t'(r));
      pend_d[r] = pend_q[r];
      if (inc && !dec)
        pend_d[r] = pend_q[r] + pend_t'(1);
      else if (dec && !inc && pend_q[r] != '0)
        pend_d[r] = pend_q[r] - pend_t'(1);
      busy[r]   = (pend_q[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;
  // Gated by reset so the read ports stay at zero while reset is held.
  assign fwd1 = reset && wb_fire && (rf.wb_addr == rf.src_reg1);
  assign fwd2 = reset && wb_fire && (rf.wb_addr == rf.src_reg2);
  assign rf.rin_reg1 = fwd1 ? rf.wb_data : stored1;
  assign rf.rin_reg2 = fwd2 ? rf.wb_data : stored2;
  assign haz1 = busy[rf.src_reg1] && !(fwd1 && pend_d[rf.src_reg1] == '0);
  assign haz2 = busy[rf.src_reg2] && !(fwd2 && pend_d[rf.src_reg2] == '0);
`else
  assign rf.rin_reg1 = stored1;
  assign rf.rin_reg2 = stored2;
  assign haz1 = busy[rf.src_reg1];
  assign haz2 = busy[rf.src_reg2];
`endif

  assign rf.stall       = haz1 || haz2;
  assign rf.issue_ready = issue_ready;
  assign rf.busy_mask   = busy;

endmodule
